// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store initiator between the MEM stage and a big-endian
// byte-lane data RAM. Drives one request at a time onto the RAM bus, holds it
// for WAIT_CYCLES extra cycles, then returns the extended load data with a
// one-cycle done_o pulse while stalling the pipeline.
// Optional build macro: DATA_MEM_ALIGN_EXC_EN adds misalign_o and completes
// misaligned halfword/word requests immediately without touching the RAM.
//
// state  | meaning
// IDLE   | waiting for req_i; bus idle
// ACCESS | bus driven, counting wait cycles
// DONE   | done_o pulse, result valid
module data_mem_ctrl #(
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        stallreq_o,
`ifdef DATA_MEM_ALIGN_EXC_EN
    output logic        misalign_o,
`endif
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [1:0]       addr_lo_q;

    logic [3:0]  sel_next;
    logic [31:0] data_next;
    logic [31:0] load_ext;
    logic        is_store;
    logic        is_half;
    logic        is_word;
    logic        misaligned;

    // Request decode: lane select, store replication and alignment class.
    always_comb begin
        sel_next  = 4'b0000;
        data_next = wdata_i;
        is_half   = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
        is_word   = (op_i == OP_LW) || (op_i == OP_SW);
        is_store  = op_i[2] && (op_i != OP_LW);
        if (is_word) begin
            sel_next = 4'b1111;
        end else if (is_half) begin
            sel_next = addr_i[1] ? 4'b0011 : 4'b1100;
        end else begin
            sel_next = 4'b1000 >> addr_i[1:0];
        end
        if (op_i == OP_SB) begin
            data_next = {4{wdata_i[7:0]}};
        end else if (op_i == OP_SH) begin
            data_next = {2{wdata_i[15:0]}};
        end
        misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
    end

    // Load extraction from the big-endian word: offset 0 lives in bits 31:24.
    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'h00;
        h = addr_lo_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
        case (addr_lo_q)
            2'd0:    b = mem_data_i[31:24];
            2'd1:    b = mem_data_i[23:16];
            2'd2:    b = mem_data_i[15:8];
            default: b = mem_data_i[7:0];
        endcase
        case (op_q)
            OP_LB:   load_ext = {{24{b[7]}}, b};
            OP_LBU:  load_ext = {24'h0, b};
            OP_LH:   load_ext = {{16{h[15]}}, h};
            OP_LHU:  load_ext = {16'h0, h};
            OP_LW:   load_ext = mem_data_i;
            default: load_ext = 32'h0;
        endcase
    end

    // The stall covers the request cycle and all bus cycles, but not DONE.
    assign stallreq_o = ((state == IDLE) && req_i) || (state == ACCESS);

    // Sequencer and registered bus/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_q       <= 3'b000;
            addr_lo_q  <= 2'b00;
            rdata_o    <= 32'h0;
            done_o     <= 1'b0;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_addr_o <= 32'h0;
            mem_sel_o  <= 4'b0000;
            mem_data_o <= 32'h0;
`ifdef DATA_MEM_ALIGN_EXC_EN
            misalign_o <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_i) begin
                        op_q      <= op_i;
                        addr_lo_q <= addr_i[1:0];
                        cnt       <= '0;
`ifdef DATA_MEM_ALIGN_EXC_EN
                        if (misaligned) begin
                            state      <= DONE;
                            done_o     <= 1'b1;
                            misalign_o <= 1'b1;
                            rdata_o    <= 32'h0;
                        end else begin
`endif
                            state      <= ACCESS;
                            mem_ce_o   <= 1'b1;
                            mem_we_o   <= is_store;
                            mem_addr_o <= addr_i;
                            mem_sel_o  <= sel_next;
                            mem_data_o <= data_next;
`ifdef DATA_MEM_ALIGN_EXC_EN
                        end
`endif
                    end
                end
                ACCESS: begin
                    if (cnt == CNT_W'(WAIT_CYCLES)) begin
                        state     <= DONE;
                        done_o    <= 1'b1;
                        rdata_o   <= load_ext;
                        mem_ce_o  <= 1'b0;
                        mem_we_o  <= 1'b0;
                        mem_sel_o <= 4'b0000;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    done_o  <= 1'b0;
                    rdata_o <= 32'h0;
`ifdef DATA_MEM_ALIGN_EXC_EN
                    misalign_o <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a small big-endian byte-lane RAM model.
module tb_data_mem_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic [2:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        stallreq_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;
`ifdef DATA_MEM_ALIGN_EXC_EN
    logic        misalign_o;
`endif

    logic [31:0] ram [16];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .done_o(done_o),
        .stallreq_o(stallreq_o),
`ifdef DATA_MEM_ALIGN_EXC_EN
        .misalign_o(misalign_o),
`endif
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    assign mem_data_i = ram[mem_addr_o[5:2]];

    always @(posedge clk) begin
        if (mem_ce_o && mem_we_o) begin
            for (int k = 0; k < 4; k++)
                if (mem_sel_o[k]) ram[mem_addr_o[5:2]][8*k +: 8] <= mem_data_o[8*k +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // One request; exp_lat is the cycle index of done_o (request cycle = 0).
    task automatic access(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic [3:0] exp_sel, input logic [31:0] exp_md,
                          input logic exp_we, input int exp_lat, input logic exp_mis);
        int  n;
        bit  seen;
        @(posedge clk); #1;
        req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd;
        #1 chk({tag, ".stall0"}, 32'(stallreq_o), 32'd1);
        n = 0; seen = 0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done_o) begin
                seen = 1;
            end else begin
                chk({tag, ".ce"}, 32'(mem_ce_o), 32'(exp_lat > 1));
                if (exp_lat > 1) begin
                    chk({tag, ".we"},    32'(mem_we_o), 32'(exp_we));
                    chk({tag, ".sel"},   32'(mem_sel_o), 32'(exp_sel));
                    chk({tag, ".addr"},  mem_addr_o, addr);
                    chk({tag, ".stall"}, 32'(stallreq_o), 32'd1);
                    if (exp_we) chk({tag, ".wdata"}, mem_data_o, exp_md);
                end
            end
        end
        if (!seen) chk({tag, ".timeout"}, 32'd0, 32'd1);
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".rdata"}, rdata_o, exp_rd);
        chk({tag, ".stall_done"}, 32'(stallreq_o), 32'd0);
        chk({tag, ".ce_done"}, 32'(mem_ce_o), 32'd0);
`ifdef DATA_MEM_ALIGN_EXC_EN
        chk({tag, ".misalign"}, 32'(misalign_o), 32'(exp_mis));
`else
        if (exp_mis) chk({tag, ".no_misalign_port"}, 32'd0, 32'd0 + 32'(exp_mis) - 32'd1);
`endif
        req_i = 1'b0;
        @(posedge clk); #1;
        chk({tag, ".done_drop"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ram[i] = 32'h0;
        ram[4] = 32'h8899AABB;
        rst = 1'b1; req_i = 1'b0; op_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst.done",  32'(done_o), 32'd0);
        chk("rst.ce",    32'(mem_ce_o), 32'd0);
        chk("rst.sel",   32'(mem_sel_o), 32'd0);
        chk("rst.rdata", rdata_o, 32'd0);
        chk("rst.addr",  mem_addr_o, 32'd0);
        chk("rst.stall", 32'(stallreq_o), 32'd0);

        access("lb11",  3'b000, 32'h11, 32'h0, 32'hFFFFFF99, 4'b0100, 32'h0, 1'b0, 2+W, 1'b0);
        access("lhu12", 3'b011, 32'h12, 32'h0, 32'h0000AABB, 4'b0011, 32'h0, 1'b0, 2+W, 1'b0);
        access("lh10",  3'b010, 32'h10, 32'h0, 32'hFFFF8899, 4'b1100, 32'h0, 1'b0, 2+W, 1'b0);
        access("lw10",  3'b100, 32'h10, 32'h0, 32'h8899AABB, 4'b1111, 32'h0, 1'b0, 2+W, 1'b0);
        access("sb13",  3'b101, 32'h13, 32'h000000CC, 32'h0, 4'b0001, 32'hCCCCCCCC, 1'b1, 2+W, 1'b0);
        access("lw_sb", 3'b100, 32'h10, 32'h0, 32'h8899AACC, 4'b1111, 32'h0, 1'b0, 2+W, 1'b0);
        access("sh12",  3'b110, 32'h12, 32'h00001234, 32'h0, 4'b0011, 32'h12341234, 1'b1, 2+W, 1'b0);
        access("lw_sh", 3'b100, 32'h10, 32'h0, 32'h88991234, 4'b1111, 32'h0, 1'b0, 2+W, 1'b0);
        access("lbu12", 3'b001, 32'h12, 32'h0, 32'h00000012, 4'b0010, 32'h0, 1'b0, 2+W, 1'b0);
        access("lb10",  3'b000, 32'h10, 32'h0, 32'hFFFFFF88, 4'b1000, 32'h0, 1'b0, 2+W, 1'b0);
        access("lh12",  3'b010, 32'h12, 32'h0, 32'h00001234, 4'b0011, 32'h0, 1'b0, 2+W, 1'b0);
        access("sw14",  3'b111, 32'h14, 32'hA5B6C7D8, 32'h0, 4'b1111, 32'hA5B6C7D8, 1'b1, 2+W, 1'b0);
        access("lw14",  3'b100, 32'h14, 32'h0, 32'hA5B6C7D8, 4'b1111, 32'h0, 1'b0, 2+W, 1'b0);

`ifdef DATA_MEM_ALIGN_EXC_EN
        access("lw12m", 3'b100, 32'h12, 32'h0, 32'h0, 4'b0000, 32'h0, 1'b0, 1, 1'b1);
        access("sw11m", 3'b111, 32'h11, 32'hFFFFFFFF, 32'h0, 4'b0000, 32'h0, 1'b0, 1, 1'b1);
        chk("ram_unchanged", ram[4], 32'h88991234);
`else
        access("lw12",  3'b100, 32'h12, 32'h0, 32'h88991234, 4'b1111, 32'h0, 1'b0, 2+W, 1'b0);
`endif

        // Reset in the second ACCESS cycle of a store.
        @(posedge clk); #1;
        req_i = 1'b1; op_i = 3'b111; addr_i = 32'h18; wdata_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("rstmid.ce1", 32'(mem_ce_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1; req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid.ce",    32'(mem_ce_o), 32'd0);
        chk("rstmid.we",    32'(mem_we_o), 32'd0);
        chk("rstmid.sel",   32'(mem_sel_o), 32'd0);
        chk("rstmid.addr",  mem_addr_o, 32'd0);
        chk("rstmid.data",  mem_data_o, 32'd0);
        chk("rstmid.done",  32'(done_o), 32'd0);
        chk("rstmid.stall", 32'(stallreq_o), 32'd0);
        repeat (W + 2) begin
            @(posedge clk); #1;
            chk("rstmid.no_done", 32'(done_o), 32'd0);
        end
        access("lw_after", 3'b100, 32'h10, 32'h0, 32'h88991234, 4'b1111, 32'h0, 1'b0, 2+W, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store initiator sitting between the MEM pipeline stage and the byte-lane data RAM.
- Accepts one load/store request at a time from MEM.
- Computes the byte-lane select and replicates store data.
- Holds the RAM bus for a configurable number of wait cycles.
- Sign/zero-extends load data.
- Stalls the pipeline until the access completes.
- Memory is big-endian: byte offset 0 maps to lane 3 (bits 31:24, sel[3]).

Parameters:
WAIT_CYCLES, 0, extra cycles the bus is held in ACCESS before completion (0..15)
CNT_W, 4, width of the wait counter; must hold WAIT_CYCLES

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_i  in  1  MEM-stage access request; held high until done_o
op_i  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
addr_i  in  32  byte address
wdata_i  in  32  store data, right-aligned
rdata_o  out  32  extended load result, valid while done_o=1
done_o  out  1  one-cycle completion pulse
stallreq_o  out  1  pipeline stall request
mem_ce_o  out  1  RAM chip enable
mem_we_o  out  1  RAM write enable
mem_addr_o  out  32  RAM byte address
mem_sel_o  out  4  RAM byte-lane select
mem_data_o  out  32  RAM write data
mem_data_i  in  32  RAM read data (combinational from mem_addr_o)

Behaviour:
- Reset: rst=1 at a clock edge forces state IDLE, counter 0, and all registered outputs to 0 (rdata_o, done_o, mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_data_o). Reset applies mid-access as well; the bus drops on that same edge.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Samples req_i. If high, latch op, addr and wdata and go to ACCESS.
  - On that edge, load the mem_* registers: ce=1, we=op[2]&(op!=100), addr=addr_i, sel, data. Clear the counter.
- ACCESS:
  - Bus held stable; counter increments each cycle.
  - When counter==WAIT_CYCLES: capture the extended mem_data_i into rdata_o (loads only; stores leave rdata_o=0), deassert mem_ce_o/mem_we_o/mem_sel_o, set done_o=1, go to DONE.
  - Stores: the RAM writes on every edge while we=1. Repeated writes of identical data are acceptable.
- DONE: done_o=1 for exactly this cycle, then go to IDLE and clear done_o. req_i is ignored in DONE; a req_i still high in the next IDLE cycle starts a new access.
- stallreq_o is combinational: (state==IDLE & req_i) | state==ACCESS. It is 0 in the DONE cycle.
- Latency with WAIT_CYCLES=0: req_i at cycle 0, bus active in cycle 1, done_o in cycle 2. In general done_o arrives at cycle 2+WAIT_CYCLES.
- Select generation:
  - Byte ops: sel = 1000 >> addr[1:0].
  - Halfword ops: addr[1]=0 gives 1100, addr[1]=1 gives 0011.
  - Word ops: 1111.
- Store data:
  - SB: wdata[7:0] replicated ×4.
  - SH: wdata[15:0] replicated ×2.
  - SW: wdata as-is.
- Load extraction:
  - Byte: lane (3-addr[1:0]).
  - Halfword: upper half if addr[1]=0, lower half otherwise.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes all 32 bits.
- mem_addr_o carries addr_i unmodified; the RAM ignores bits [1:0].
- Misalignment without the optional feature: LH/LHU/SH ignore addr[0]; LW/SW ignore addr[1:0].

Optional Feature:
Macro DATA_MEM_ALIGN_EXC_EN.
- Defined:
  - Adds output port misalign_o (1 bit).
  - In IDLE, a request with halfword op and addr[0]=1, or word op and addr[1:0]!=00, goes straight to DONE. mem_ce_o stays 0, so no RAM write occurs.
  - done_o=1, misalign_o=1 and rdata_o=0 for that single cycle, so the access completes 1 cycle after the request.
  - misalign_o is 0 at all other times and on reset.
- Undefined: no misalign_o port; misaligned addresses are handled as described in Behaviour.

Test Plan:
1. RAM word 0x10 preloaded 0x8899AABB, WAIT_CYCLES=0; LB 0x11 -> done_o at cycle 2, rdata_o=0xFFFFFF99, mem_sel_o=0100 during cycle 1, stallreq_o high in cycles 0-1.
2. LHU 0x12 -> rdata_o=0x0000AABB. LH 0x10 -> 0xFFFF8899. LW 0x10 -> 0x8899AABB.
3. SB 0x13 with wdata 0x000000CC -> mem_we_o=1, mem_sel_o=0001, mem_data_o=0xCCCCCCCC; a following LW 0x10 returns 0x8899AACC and rdata_o=0 after the store.
4. WAIT_CYCLES=2; SH 0x12 with data 0x1234 -> bus held cycles 1-3 with sel=0011, data 0x12341234; done_o at cycle 4; a subsequent LW 0x10 returns 0x88991234.
5. DATA_MEM_ALIGN_EXC_EN defined; LW 0x12 -> done_o and misalign_o at cycle 1, mem_ce_o never 1, RAM contents unchanged. Undefined: same LW 0x12 returns the full word at 0x10.
6. WAIT_CYCLES=3; rst=1 in the second ACCESS cycle of an SW -> all outputs 0 after that edge, no done_o, next req_i starts a clean access from IDLE.
